// File: rtl/fma16_seq_pkg.sv
// Shared types and field layout for the fma16 vector sequencer.
// Vector layout: {x[75:60], y[59:44], z[43:28], ctrl[27:20], rexp[19:4], fexp[3:0]}.
package fma16_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSettle,
    StCheck,
    StDone
  } seq_state_e;

  localparam int unsigned VecW    = 76;
  localparam int unsigned SettleW = 4;

  // Vector field LSB offsets
  localparam int unsigned XLsb    = 60;
  localparam int unsigned YLsb    = 44;
  localparam int unsigned ZLsb    = 28;
  localparam int unsigned CtrlLsb = 20;
  localparam int unsigned RexpLsb = 4;
  localparam int unsigned FexpLsb = 0;

  // Bit positions inside the 8-bit ctrl field
  localparam int unsigned CtrlNegz  = 0;
  localparam int unsigned CtrlNegp  = 1;
  localparam int unsigned CtrlAdd   = 2;
  localparam int unsigned CtrlMul   = 3;
  localparam int unsigned CtrlRmLsb = 4;

  // fma16 flag bit indices
  localparam int unsigned FlagInexact   = 0;
  localparam int unsigned FlagUnderflow = 1;
  localparam int unsigned FlagOverflow  = 2;
  localparam int unsigned FlagInvalid   = 3;

endpackage

// File: rtl/fma16_seq_cmp.sv
// Result/flag comparator with first-mismatch capture register.
module fma16_seq_cmp #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check,
  input  logic             clear,
  input  logic [CNT_W-1:0] index,
  input  logic [15:0]      result,
  input  logic [3:0]       flags,
  input  logic [15:0]      rexp,
  input  logic [3:0]       fexp,
  output logic             mismatch,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_index,
  output logic [15:0]      first_err_result,
  output logic [3:0]       first_err_flags
);

  // Mismatch on any result or flag difference
  always_comb begin
    mismatch = (result != rexp) | (flags != fexp);
  end

  // Capture only the first failing vector of a run
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      first_err_valid  <= 1'b0;
      first_err_index  <= '0;
      first_err_result <= '0;
      first_err_flags  <= '0;
    end else if (check && mismatch && !first_err_valid) begin
      first_err_valid  <= 1'b1;
      first_err_index  <= index;
      first_err_result <= result;
      first_err_flags  <= flags;
    end
  end

endmodule

// File: rtl/fma16_vector_sequencer.sv
// Drives packed test vectors into a combinational fma16 and checks its outputs.
// Optional: define FMA16_SEQ_STOP_ON_ERR_EN to end the run at the first mismatch.
module fma16_vector_sequencer
  import fma16_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [VecW-1:0]  vec_data,
  input  logic             vec_last,
  output logic [15:0]      fma_x,
  output logic [15:0]      fma_y,
  output logic [15:0]      fma_z,
  output logic             fma_mul,
  output logic             fma_add,
  output logic             fma_negp,
  output logic             fma_negz,
  output logic [1:0]       fma_roundmode,
  input  logic [15:0]      fma_result,
  input  logic [3:0]       fma_flags,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_index,
  output logic [CNT_W-1:0] error_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_index,
  output logic [15:0]      first_err_result,
  output logic [3:0]       first_err_flags
);

  seq_state_e         state_q, state_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [15:0]        x_q, y_q, z_q, rexp_q;
  logic [5:0]         ctrl_q;
  logic [3:0]         fexp_q;
  logic               last_q;
  logic [CNT_W-1:0]   vec_index_q, error_count_q;
  logic               accept, clear, check, mismatch, stop;

  // ctrl[7:6] carry no meaning for fma16
  logic unused_ctrl_hi;
  assign unused_ctrl_hi = ^vec_data[CtrlLsb+6 +: 2];

`ifdef FMA16_SEQ_STOP_ON_ERR_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  // Next-state and per-state strobes
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    accept   = 1'b0;
    clear    = 1'b0;
    check    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          clear   = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (vec_valid) begin
          accept   = 1'b1;
          settle_d = SettleW'(SETTLE_CYCLES - 1);
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == '0) state_d = StCheck;
        else                settle_d = settle_q - SettleW'(1);
      end
      StCheck: begin
        check   = 1'b1;
        state_d = (last_q || stop) ? StDone : StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand/expected latches and saturating counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      settle_q      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      z_q           <= '0;
      ctrl_q        <= '0;
      rexp_q        <= '0;
      fexp_q        <= '0;
      last_q        <= 1'b0;
      vec_index_q   <= '0;
      error_count_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      if (accept) begin
        x_q    <= vec_data[XLsb +: 16];
        y_q    <= vec_data[YLsb +: 16];
        z_q    <= vec_data[ZLsb +: 16];
        ctrl_q <= vec_data[CtrlLsb +: 6];
        rexp_q <= vec_data[RexpLsb +: 16];
        fexp_q <= vec_data[FexpLsb +: 4];
        last_q <= vec_last;
      end
      if (clear) begin
        vec_index_q   <= '0;
        error_count_q <= '0;
      end else if (check) begin
        if (!(&vec_index_q)) vec_index_q <= vec_index_q + CNT_W'(1);
        if (mismatch && !(&error_count_q)) error_count_q <= error_count_q + CNT_W'(1);
      end
    end
  end

  fma16_seq_cmp #(
    .CNT_W (CNT_W)
  ) u_cmp (
    .clk              (clk),
    .reset            (reset),
    .check            (check),
    .clear            (clear),
    .index            (vec_index_q),
    .result           (fma_result),
    .flags            (fma_flags),
    .rexp             (rexp_q),
    .fexp             (fexp_q),
    .mismatch         (mismatch),
    .first_err_valid  (first_err_valid),
    .first_err_index  (first_err_index),
    .first_err_result (first_err_result),
    .first_err_flags  (first_err_flags)
  );

  // Outputs decoded from registered state only
  always_comb begin
    vec_ready     = (state_q == StFetch);
    busy          = (state_q == StFetch) || (state_q == StSettle) || (state_q == StCheck);
    done          = (state_q == StDone);
    fma_x         = x_q;
    fma_y         = y_q;
    fma_z         = z_q;
    fma_mul       = ctrl_q[CtrlMul];
    fma_add       = ctrl_q[CtrlAdd];
    fma_negp      = ctrl_q[CtrlNegp];
    fma_negz      = ctrl_q[CtrlNegz];
    fma_roundmode = ctrl_q[CtrlRmLsb +: 2];
    vec_index     = vec_index_q;
    error_count   = error_count_q;
  end

endmodule

// File: doc/fma16_vector_sequencer.md
Name: fma16_vector_sequencer

Overview:
Synthesizable driver/checker stage wrapped around the combinational fma16 datapath. It accepts packed 76-bit test vectors on a valid/ready stream, decodes them into fma16 operand and control inputs, waits for the result to settle, then compares fma16 result/flags against the expected fields. It keeps pass/error counts and captures the first failing vector, so fma16 regressions can run on FPGA or emulation without a simulator testbench.

Parameters:
SETTLE_CYCLES, 1, cycles between driving operands and sampling result; legal range 1..15
CNT_W, 32, width of vector index and pass/error counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  pulse: clear counters and begin run (honoured in IDLE or DONE only)
vec_valid  in  1  upstream vector valid
vec_ready  out  1  sequencer accepts vector this cycle
vec_data  in  76  {x[75:60], y[59:44], z[43:28], ctrl[27:20], rexp[19:4], fexp[3:0]}
vec_last  in  1  qualifies the final vector of the run
fma_x, fma_y, fma_z  out  16 each  operands to fma16
fma_mul, fma_add, fma_negp, fma_negz  out  1 each  decoded ctrl[3], ctrl[2], ctrl[1], ctrl[0]
fma_roundmode  out  2  ctrl[5:4]; ctrl[7:6] ignored
fma_result  in  16  fma16 result
fma_flags  in  4  fma16 flags {invalid, overflow, underflow, inexact}
busy  out  1  FSM not in IDLE/DONE
done  out  1  run complete, held until start or reset
vec_index  out  CNT_W  vectors checked this run
error_count  out  CNT_W  mismatching vectors
first_err_valid  out  1  a mismatch has been captured
first_err_index  out  CNT_W  index of first mismatch
first_err_result  out  16  fma_result at first mismatch
first_err_flags  out  4  fma_flags at first mismatch

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs and operand/expected registers 0; applies mid-run, abandoning the current vector without counting it.
- States: IDLE, FETCH, SETTLE, CHECK, DONE.
- IDLE: vec_ready=0; start -> clear counters/capture, go FETCH.
- FETCH: vec_ready=1; on vec_valid, latch operands, ctrl, rexp, fexp and vec_last; load settle counter with SETTLE_CYCLES-1; go SETTLE. fma_* outputs come from registers and change only on acceptance.
- SETTLE: decrement counter; at 0 go CHECK. Latency from acceptance to CHECK is SETTLE_CYCLES cycles.
- CHECK: mismatch = (fma_result != rexp) | (fma_flags != fexp). On mismatch, error_count++; if first_err_valid==0, capture index/result/flags and set first_err_valid. vec_index++ always. Latched last -> DONE, else FETCH.
- DONE: done=1, vec_ready=0; start -> clear, go FETCH.
- start is ignored in FETCH/SETTLE/CHECK.
- Counters saturate at all-ones and do not wrap.
- vec_valid while vec_ready=0 is not consumed; the upstream holds data. No combinational path from vec_valid to vec_ready.

Optional Feature:
FMA16_SEQ_STOP_ON_ERR_EN: when defined, CHECK with a mismatch goes to DONE regardless of vec_last, after counting and capture. vec_index includes the failing vector. When not defined, the run continues to vec_last.

Decomposition:
- Package fma16_seq_pkg holds:
  - state enum
  - vector field bit offsets
  - ctrl bit positions
  - flag bit indices
- One sub-module, fma16_seq_cmp: combinational compare plus first-error capture register.

Test Plan:
- Vector 3c00_3c00_0000_18_3c00_0 with vec_last=1 and the real fma16 -> fma_mul=1, roundmode=01; done after SETTLE_CYCLES+2 cycles; vec_index=1, error_count=0.
- Three vectors, the second with rexp corrupted to 3c01 -> error_count=1; first_err_index=1; first_err_result=3c00; vec_index=3.
- Hold vec_valid low for 5 cycles in FETCH -> vec_ready stays 1, state unchanged, no counter change; then send vector -> normal check.
- Assert reset low during SETTLE -> next cycle all outputs 0, state IDLE; start then rerun -> counts start from 0.
- Build with FMA16_SEQ_STOP_ON_ERR_EN, first vector failing, second pending -> done after the first check; second vector not accepted (vec_ready=0).
- SETTLE_CYCLES=4 -> CHECK occurs exactly 4 cycles after acceptance; start pulsed in DONE clears error_count and first_err_valid.
